// File: rtl/clock_pkg.sv
// Shared constants and FSM encoding for the UTC correction path.
package clock_pkg;

    localparam int RST_HOUR_2 = 1;
    localparam int RST_HOUR_1 = 2;

    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR24_MAX = 23;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        INC,
        ZONE,
        WRITE
    } state_t;

endpackage

// File: rtl/bin_to_bcd60.sv
// Combinational 0..59 binary to tens/ones BCD pair.
module bin_to_bcd60 (
    input  logic [5:0] bin,
    output logic [2:0] tens,
    output logic [3:0] ones
);

    always_comb begin
        tens = 3'd0;
        ones = 4'(bin);
        if (bin >= 6'd50) begin
            tens = 3'd5;
            ones = 4'(bin - 6'd50);
        end else if (bin >= 6'd40) begin
            tens = 3'd4;
            ones = 4'(bin - 6'd40);
        end else if (bin >= 6'd30) begin
            tens = 3'd3;
            ones = 4'(bin - 6'd30);
        end else if (bin >= 6'd20) begin
            tens = 3'd2;
            ones = 4'(bin - 6'd20);
        end else if (bin >= 6'd10) begin
            tens = 3'd1;
            ones = 4'(bin - 6'd10);
        end
    end

endmodule

// File: rtl/utc_time_correction.sv
// Advances parsed UTC BCD time by the PPS lead, applies a timezone offset,
// and presents 12-hour BCD digits for the clock counter to load on PPS.
module utc_time_correction #(
    parameter int TZ_OFFSET   = -5,
    parameter int ADD_SECONDS = 1,
    parameter int STALE_PPS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pps_in,
    input  logic       utc_strobe,
    input  logic [3:0] utc_sec_1,
    input  logic [2:0] utc_sec_2,
    input  logic [3:0] utc_min_1,
    input  logic [2:0] utc_min_2,
    input  logic [3:0] utc_hour_1,
    input  logic [1:0] utc_hour_2,
    output logic [3:0] sec_1_out,
    output logic [2:0] sec_2_out,
    output logic [3:0] min_1_out,
    output logic [2:0] min_2_out,
    output logic [3:0] hour_1_out,
    output logic [1:0] hour_2_out,
    output logic       pm,
    output logic       time_valid,
    output logic       busy,
    output logic       input_error
);
    import clock_pkg::*;

    // Biasing by 24 keeps the zone sum non-negative for any legal offset.
    localparam logic [5:0] ZONE_BIAS = 6'(24 + TZ_OFFSET);

    state_t     state;
    logic [3:0] raw_sec_1, raw_min_1, raw_hour_1;
    logic [2:0] raw_sec_2, raw_min_2;
    logic [1:0] raw_hour_2;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic [3:0] hour12;
    logic       pm_pend;
    logic [2:0] stale_cnt;

    logic [6:0] sec_bin, min_bin;
    logic [5:0] hour_bin;
    logic       raw_ok;
    logic [5:0] zone_sum, h24;
    logic [2:0] sec_tens, min_tens, hour_tens;
    logic [3:0] sec_ones, min_ones, hour_ones;

    assign busy = (state != IDLE);

    always_comb begin
        sec_bin  = 7'(raw_sec_2) * 7'd10 + 7'(raw_sec_1);
        min_bin  = 7'(raw_min_2) * 7'd10 + 7'(raw_min_1);
        hour_bin = 6'(raw_hour_2) * 6'd10 + 6'(raw_hour_1);
        raw_ok   = (raw_sec_1 <= 4'd9) && (raw_min_1 <= 4'd9) && (raw_hour_1 <= 4'd9)
                && (raw_sec_2 <= 3'd5) && (raw_min_2 <= 3'd5)
                && (hour_bin <= 6'(HOUR24_MAX));
        zone_sum = 6'(hour) + ZONE_BIAS;
        if (zone_sum >= 6'd48)
            h24 = zone_sum - 6'd48;
        else if (zone_sum >= 6'd24)
            h24 = zone_sum - 6'd24;
        else
            h24 = zone_sum;
    end

    bin_to_bcd60 u_sec_bcd  (.bin(sec),              .tens(sec_tens),  .ones(sec_ones));
    bin_to_bcd60 u_min_bcd  (.bin(min),              .tens(min_tens),  .ones(min_ones));
    bin_to_bcd60 u_hour_bcd (.bin({2'b00, hour12}),  .tens(hour_tens), .ones(hour_ones));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            sec_1_out   <= 4'd0;
            sec_2_out   <= 3'd0;
            min_1_out   <= 4'd0;
            min_2_out   <= 3'd0;
            hour_1_out  <= 4'(RST_HOUR_1);
            hour_2_out  <= 2'(RST_HOUR_2);
            pm          <= 1'b0;
            time_valid  <= 1'b0;
            input_error <= 1'b0;
            stale_cnt   <= 3'd0;
            raw_sec_1   <= 4'd0;
            raw_sec_2   <= 3'd0;
            raw_min_1   <= 4'd0;
            raw_min_2   <= 3'd0;
            raw_hour_1  <= 4'd0;
            raw_hour_2  <= 2'd0;
            sec         <= 6'd0;
            min         <= 6'd0;
            hour        <= 5'd0;
            hour12      <= 4'd12;
            pm_pend     <= 1'b0;
        end else begin
            input_error <= 1'b0;
            // A WRITE in the same cycle as pps_in takes priority below.
            if (pps_in && time_valid && state != WRITE) begin
                if (stale_cnt != 3'(STALE_PPS))
                    stale_cnt <= stale_cnt + 3'd1;
                if (stale_cnt + 3'd1 >= 3'(STALE_PPS))
                    time_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (utc_strobe) begin
                        raw_sec_1  <= utc_sec_1;
                        raw_sec_2  <= utc_sec_2;
                        raw_min_1  <= utc_min_1;
                        raw_min_2  <= utc_min_2;
                        raw_hour_1 <= utc_hour_1;
                        raw_hour_2 <= utc_hour_2;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    if (raw_ok) begin
                        sec   <= 6'(sec_bin);
                        min   <= 6'(min_bin);
                        hour  <= 5'(hour_bin);
                        state <= INC;
                    end else begin
                        input_error <= 1'b1;
                        state       <= IDLE;
                    end
                end
                INC: begin
                    if (ADD_SECONDS != 0) begin
                        if (sec == 6'(SEC_MAX)) begin
                            sec <= 6'd0;
                            if (min == 6'(MIN_MAX)) begin
                                min  <= 6'd0;
                                hour <= (hour == 5'(HOUR24_MAX)) ? 5'd0 : hour + 5'd1;
                            end else begin
                                min <= min + 6'd1;
                            end
                        end else begin
                            sec <= sec + 6'd1;
                        end
                    end
                    state <= ZONE;
                end
                ZONE: begin
                    if (h24 == 6'd0)
                        hour12 <= 4'd12;
                    else if (h24 > 6'd12)
                        hour12 <= 4'(h24 - 6'd12);
                    else
                        hour12 <= 4'(h24);
                    pm_pend <= (h24 >= 6'd12);
                    state   <= WRITE;
                end
                WRITE: begin
                    sec_1_out  <= sec_ones;
                    sec_2_out  <= sec_tens;
                    min_1_out  <= min_ones;
                    min_2_out  <= min_tens;
                    hour_1_out <= hour_ones;
                    hour_2_out <= 2'(hour_tens);
                    pm         <= pm_pend;
                    time_valid <= 1'b1;
                    stale_cnt  <= 3'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_utc_time_correction.sv
// Directed bench for utc_time_correction: a -5 h instance and a +2 h instance share stimulus.
module tb_utc_time_correction;

    logic       clk = 1'b0;
    logic       reset;
    logic       pps_in;
    logic       utc_strobe;
    logic [3:0] utc_sec_1, utc_min_1, utc_hour_1;
    logic [2:0] utc_sec_2, utc_min_2;
    logic [1:0] utc_hour_2;

    logic [3:0] a_sec_1, a_min_1, a_hour_1, b_sec_1, b_min_1, b_hour_1;
    logic [2:0] a_sec_2, a_min_2, b_sec_2, b_min_2;
    logic [1:0] a_hour_2, b_hour_2;
    logic       a_pm, a_valid, a_busy, a_err;
    logic       b_pm, b_valid, b_busy, b_err;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    utc_time_correction #(.TZ_OFFSET(-5), .ADD_SECONDS(1), .STALE_PPS(2)) dut (
        .clk(clk), .reset(reset), .pps_in(pps_in), .utc_strobe(utc_strobe),
        .utc_sec_1(utc_sec_1), .utc_sec_2(utc_sec_2), .utc_min_1(utc_min_1),
        .utc_min_2(utc_min_2), .utc_hour_1(utc_hour_1), .utc_hour_2(utc_hour_2),
        .sec_1_out(a_sec_1), .sec_2_out(a_sec_2), .min_1_out(a_min_1),
        .min_2_out(a_min_2), .hour_1_out(a_hour_1), .hour_2_out(a_hour_2),
        .pm(a_pm), .time_valid(a_valid), .busy(a_busy), .input_error(a_err)
    );

    utc_time_correction #(.TZ_OFFSET(2), .ADD_SECONDS(1), .STALE_PPS(2)) dut_tz2 (
        .clk(clk), .reset(reset), .pps_in(pps_in), .utc_strobe(utc_strobe),
        .utc_sec_1(utc_sec_1), .utc_sec_2(utc_sec_2), .utc_min_1(utc_min_1),
        .utc_min_2(utc_min_2), .utc_hour_1(utc_hour_1), .utc_hour_2(utc_hour_2),
        .sec_1_out(b_sec_1), .sec_2_out(b_sec_2), .min_1_out(b_min_1),
        .min_2_out(b_min_2), .hour_1_out(b_hour_1), .hour_2_out(b_hour_2),
        .pm(b_pm), .time_valid(b_valid), .busy(b_busy), .input_error(b_err)
    );

    // Packed {hh, mm, ss, pm} views, 21 bits each, compared against hand-built constants.
    logic [20:0] a_time, b_time;
    assign a_time = {a_hour_2, a_hour_1, a_min_2, a_min_1, a_sec_2, a_sec_1, a_pm};
    assign b_time = {b_hour_2, b_hour_1, b_min_2, b_min_1, b_sec_2, b_sec_1, b_pm};

    function automatic logic [20:0] t12(input int h2, input int h1, input int m2,
                                        input int m1, input int s2, input int s1, input int p);
        return {2'(h2), 4'(h1), 3'(m2), 4'(m1), 3'(s2), 4'(s1), 1'(p)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int h2, input int h1, input int m2, input int m1,
                        input int s2, input int s1);
        utc_hour_2 = 2'(h2); utc_hour_1 = 4'(h1);
        utc_min_2  = 3'(m2); utc_min_1  = 4'(m1);
        utc_sec_2  = 3'(s2); utc_sec_1  = 4'(s1);
        utc_strobe = 1'b1;
        tick();
        utc_strobe = 1'b0;
    endtask

    task automatic pulse_pps();
        pps_in = 1'b1;
        tick();
        pps_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; pps_in = 1'b0; utc_strobe = 1'b0;
        send(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (a_time !== t12(1, 2, 0, 0, 0, 0, 0))
            $display("[TB] FAIL reset_time got=%h exp=%h", a_time, t12(1, 2, 0, 0, 0, 0, 0));
        else passed++;
        checks++;
        if ({a_valid, a_busy, a_err} !== 3'b000)
            $display("[TB] FAIL reset_flags got=%b exp=000", {a_valid, a_busy, a_err});
        else passed++;
    endtask

    task automatic test_basic();
        send(1, 7, 3, 0, 4, 5);
        checks++;
        if (a_busy !== 1'b1) $display("[TB] FAIL busy_T got=%b exp=1", a_busy); else passed++;
        tick(); tick(); tick();
        checks++;
        if (a_busy !== 1'b1 || a_time !== t12(1, 2, 0, 0, 0, 0, 0))
            $display("[TB] FAIL no_partial got busy=%b time=%h exp busy=1 time=%h",
                     a_busy, a_time, t12(1, 2, 0, 0, 0, 0, 0));
        else passed++;
        tick();
        checks++;
        if (a_time !== t12(1, 2, 3, 0, 4, 6, 1))
            $display("[TB] FAIL basic_time got=%h exp=%h", a_time, t12(1, 2, 3, 0, 4, 6, 1));
        else passed++;
        checks++;
        if ({a_valid, a_busy} !== 2'b10)
            $display("[TB] FAIL basic_flags got=%b exp=10", {a_valid, a_busy});
        else passed++;
        checks++;
        if (b_time !== t12(0, 7, 3, 0, 4, 6, 1))
            $display("[TB] FAIL basic_tz2 got=%h exp=%h", b_time, t12(0, 7, 3, 0, 4, 6, 1));
        else passed++;
    endtask

    task automatic test_rollover();
        send(0, 4, 5, 9, 5, 9);
        repeat (4) tick();
        checks++;
        if (a_time !== t12(1, 2, 0, 0, 0, 0, 0))
            $display("[TB] FAIL midnight got=%h exp=%h", a_time, t12(1, 2, 0, 0, 0, 0, 0));
        else passed++;
        send(2, 3, 5, 9, 5, 9);
        repeat (4) tick();
        checks++;
        if (b_time !== t12(0, 2, 0, 0, 0, 0, 0))
            $display("[TB] FAIL day_wrap_tz2 got=%h exp=%h", b_time, t12(0, 2, 0, 0, 0, 0, 0));
        else passed++;
        checks++;
        if (a_time !== t12(0, 7, 0, 0, 0, 0, 1))
            $display("[TB] FAIL day_wrap_tzm5 got=%h exp=%h", a_time, t12(0, 7, 0, 0, 0, 0, 1));
        else passed++;
        send(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        checks++;
        if (a_time !== t12(0, 7, 0, 0, 0, 1, 1))
            $display("[TB] FAIL neg_wrap got=%h exp=%h", a_time, t12(0, 7, 0, 0, 0, 1, 1));
        else passed++;
    endtask

    task automatic test_input_error();
        logic [20:0] held;
        held = t12(0, 7, 0, 0, 0, 1, 1);
        send(2, 5, 0, 0, 0, 0);
        tick();
        checks++;
        if ({a_err, a_busy} !== 2'b10)
            $display("[TB] FAIL err_hour got=%b exp=10", {a_err, a_busy});
        else passed++;
        tick();
        checks++;
        if (a_err !== 1'b0) $display("[TB] FAIL err_one_cycle got=%b exp=0", a_err); else passed++;
        send(1, 2, 6, 1, 0, 0);
        tick();
        checks++;
        if (a_err !== 1'b1) $display("[TB] FAIL err_min got=%b exp=1", a_err); else passed++;
        send(1, 2, 0, 0, 0, 10);
        tick();
        checks++;
        if (a_err !== 1'b1) $display("[TB] FAIL err_digit got=%b exp=1", a_err); else passed++;
        repeat (4) tick();
        checks++;
        if (a_time !== held || a_valid !== 1'b1 || a_err !== 1'b0)
            $display("[TB] FAIL err_hold got time=%h valid=%b err=%b exp time=%h valid=1 err=0",
                     a_time, a_valid, a_err, held);
        else passed++;
    endtask

    task automatic test_stale();
        pulse_pps();
        checks++;
        if (a_valid !== 1'b1) $display("[TB] FAIL stale_first got=%b exp=1", a_valid); else passed++;
        pulse_pps();
        checks++;
        if (a_valid !== 1'b0 || a_time !== t12(0, 7, 0, 0, 0, 1, 1))
            $display("[TB] FAIL stale_second got valid=%b time=%h exp valid=0 time=%h",
                     a_valid, a_time, t12(0, 7, 0, 0, 0, 1, 1));
        else passed++;
        // pps on the WRITE edge: the counter restarts, so one later pps keeps valid high
        send(1, 0, 1, 5, 2, 0);
        tick(); tick(); tick();
        pulse_pps();
        checks++;
        if (a_valid !== 1'b1 || a_time !== t12(0, 5, 1, 5, 2, 1, 0))
            $display("[TB] FAIL pps_write got valid=%b time=%h exp valid=1 time=%h",
                     a_valid, a_time, t12(0, 5, 1, 5, 2, 1, 0));
        else passed++;
        pulse_pps();
        checks++;
        if (a_valid !== 1'b1) $display("[TB] FAIL pps_after_write got=%b exp=1", a_valid); else passed++;
        pulse_pps();
        checks++;
        if (a_valid !== 1'b0) $display("[TB] FAIL pps_stale_again got=%b exp=0", a_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        send(1, 8, 2, 0, 1, 0);
        tick();
        send(0, 9, 0, 0, 0, 0);
        tick(); tick();
        checks++;
        if (a_time !== t12(0, 1, 2, 0, 1, 1, 1))
            $display("[TB] FAIL b2b_first got=%h exp=%h", a_time, t12(0, 1, 2, 0, 1, 1, 1));
        else passed++;
        send(1, 1, 0, 0, 0, 8);
        checks++;
        if (a_busy !== 1'b1) $display("[TB] FAIL b2b_accept got=%b exp=1", a_busy); else passed++;
        repeat (4) tick();
        checks++;
        if (a_time !== t12(0, 6, 0, 0, 0, 9, 0))
            $display("[TB] FAIL b2b_second got=%h exp=%h", a_time, t12(0, 6, 0, 0, 0, 9, 0));
        else passed++;
        repeat (6) tick();
        checks++;
        if (a_time !== t12(0, 6, 0, 0, 0, 9, 0) || a_busy !== 1'b0)
            $display("[TB] FAIL b2b_single_write got time=%h busy=%b exp time=%h busy=0",
                     a_time, a_busy, t12(0, 6, 0, 0, 0, 9, 0));
        else passed++;
    endtask

    task automatic test_reset_mid();
        send(1, 7, 3, 0, 4, 5);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (a_time !== t12(1, 2, 0, 0, 0, 0, 0) || {a_busy, a_valid} !== 2'b00)
            $display("[TB] FAIL reset_mid got time=%h busy/valid=%b exp time=%h busy/valid=00",
                     a_time, {a_busy, a_valid}, t12(1, 2, 0, 0, 0, 0, 0));
        else passed++;
        tick(); tick(); tick();
        checks++;
        if (a_time !== t12(1, 2, 0, 0, 0, 0, 0))
            $display("[TB] FAIL reset_abandon got=%h exp=%h", a_time, t12(1, 2, 0, 0, 0, 0, 0));
        else passed++;
        send(0, 8, 0, 0, 0, 0);
        repeat (4) tick();
        checks++;
        if (a_time !== t12(0, 3, 0, 0, 0, 1, 0) || a_valid !== 1'b1)
            $display("[TB] FAIL after_reset got time=%h valid=%b exp time=%h valid=1",
                     a_time, a_valid, t12(0, 3, 0, 0, 0, 1, 0));
        else passed++;
        checks++;
        if (b_time !== t12(1, 0, 0, 0, 0, 1, 0))
            $display("[TB] FAIL after_reset_tz2 got=%h exp=%h", b_time, t12(1, 0, 0, 0, 0, 1, 0));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rollover();
        test_input_error();
        test_stale();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
